// File: rtl/freq_div_prog.sv
// freq_div_prog: multi-channel programmable clock divider.
// Each channel divides clk_in by a runtime-loadable integer N (2..2^CNT_W-1).
// Divisor loads are double-buffered and only take effect at a period
// boundary (counter wrap, enable restart, or while disabled), so clk_out
// never produces a runt pulse.
// Optional build macro: FREQ_DIV_ODD50_EN adds a negedge helper flop per
// channel so that odd divisors give an exact 50% duty cycle.
module freq_div_prog #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         en,
  input  logic [NUM_CH*CNT_W-1:0]   div_val,
  input  logic [NUM_CH-1:0]         div_load,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         upd_pending
);

  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE_VAL = CNT_W'(1);

  // Divisors below 2 cannot produce a clock, so they are raised to 2.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (v < MIN_VAL) begin
      res = MIN_VAL;
    end else begin
      res = v;
    end
    return res;
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_run;
    logic             r_out_pos;
    logic             r_tick;

    logic [CNT_W-1:0] w_ld_val;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_act_nxt;
    logic [CNT_W-1:0] w_shd_nxt;
    logic             w_pend_nxt;
    logic             w_pos_nxt;
    logic             w_tick_nxt;
    logic             w_wrap;
    logic             w_start;

    assign w_ld_val = clamp_div(div_val[k*CNT_W +: CNT_W]);

    // Next-state logic: counting, boundary detection and divisor hand-over.
    always_comb begin
      w_cnt_nxt  = r_cnt;
      w_act_nxt  = r_active;
      w_shd_nxt  = r_shadow;
      w_pend_nxt = r_pending;
      w_pos_nxt  = 1'b0;
      w_tick_nxt = 1'b0;
      w_start    = 1'b0;
      w_wrap     = 1'b0;
      if (!en[k]) begin
        // Disabled: park the counter; any load or waiting update applies now.
        w_cnt_nxt  = '0;
        w_pend_nxt = 1'b0;
        if (div_load[k]) begin
          w_act_nxt = w_ld_val;
          w_shd_nxt = w_ld_val;
        end else if (r_pending) begin
          w_act_nxt = r_shadow;
        end else begin
          w_act_nxt = r_active;
        end
      end else begin
        // First enabled edge restarts the period; otherwise wrap at N-1.
        w_start = ~r_run;
        w_wrap  = r_run & (r_cnt >= (r_active - ONE_VAL));
        if (w_start || w_wrap) begin
          w_cnt_nxt  = '0;
          w_pend_nxt = 1'b0;
          if (div_load[k]) begin
            w_act_nxt = w_ld_val;
            w_shd_nxt = w_ld_val;
          end else if (r_pending) begin
            w_act_nxt = r_shadow;
          end else begin
            w_act_nxt = r_active;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE_VAL;
          if (div_load[k]) begin
            w_shd_nxt  = w_ld_val;
            w_pend_nxt = 1'b1;
          end else begin
            w_shd_nxt  = r_shadow;
          end
        end
        w_tick_nxt = w_wrap;
        // Half-period uses the divisor that governs the upcoming period.
        w_pos_nxt  = (w_cnt_nxt < (w_act_nxt >> 1));
      end
    end

    // Channel state registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt     <= '0;
        r_active  <= DEF_VAL;
        r_shadow  <= DEF_VAL;
        r_pending <= 1'b0;
        r_run     <= 1'b0;
        r_out_pos <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        r_cnt     <= w_cnt_nxt;
        r_active  <= w_act_nxt;
        r_shadow  <= w_shd_nxt;
        r_pending <= w_pend_nxt;
        r_run     <= en[k];
        r_out_pos <= w_pos_nxt;
        r_tick    <= w_tick_nxt;
      end
    end

    assign tick[k]        = r_tick;
    assign upd_pending[k] = r_pending;

`ifdef FREQ_DIV_ODD50_EN
    logic r_out_neg;

    // Half-cycle delayed copy of the output, only kept for odd divisors.
    always_ff @(negedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        r_out_neg <= 1'b0;
      end else begin
        r_out_neg <= r_out_pos & r_active[0];
      end
    end

    assign clk_out[k] = r_out_pos | r_out_neg;
`else
    assign clk_out[k] = r_out_pos;
`endif
  end

endmodule
